// File: rtl/sm_product_accumulator.sv
// Sums a stream of sign-magnitude products into one saturated two's-complement
// result per element, with valid/ready handshakes on both sides.
module sm_product_accumulator #(
  parameter int P     = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [P-1:0]     in_prod_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_sum_o,
  output logic             out_sat_o
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic                      alive_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [CNT_W-1:0]   len_q, len_d;
  logic        [OUT_W-1:0]   sum_q, sum_d;
  logic                      sat_q, sat_d;

  logic signed [ACC_W-1:0]   mag, term, acc_nxt;
  logic        [CNT_W-1:0]   cnt_nxt, len_eff;
  logic                      accept;

  // Negative zero falls out as 0 since -0 == 0.
  assign mag  = {{(ACC_W-P+1){1'b0}}, in_prod_i[P-2:0]};
  assign term = in_prod_i[P-1] ? -mag : mag;

  assign in_ready_o  = alive_q && (state_q != OUT);
  assign out_valid_o = (state_q == OUT);
  assign out_sum_o   = sum_q;
  assign out_sat_o   = sat_q;
  assign accept      = in_valid_i && in_ready_o;

  assign acc_nxt = (state_q == IDLE) ? term : acc_q + term;
  assign cnt_nxt = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign len_eff = (state_q == IDLE) ? ((cfg_len_i == '0) ? CNT_W'(1) : cfg_len_i) : len_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = acc_nxt;
          cnt_d   = cnt_nxt;
          len_d   = len_eff;
          state_d = ACC;
          if (cnt_nxt == len_eff) begin
            state_d = OUT;
            if (acc_nxt > SAT_MAX) begin
              sum_d = SAT_MAX[OUT_W-1:0];
              sat_d = 1'b1;
            end else if (acc_nxt < SAT_MIN) begin
              sum_d = SAT_MIN[OUT_W-1:0];
              sat_d = 1'b1;
            end else begin
              sum_d = acc_nxt[OUT_W-1:0];
              sat_d = 1'b0;
            end
          end
        end
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed bench for sm_product_accumulator; inputs change and outputs are
// sampled on the falling edge.
module tb_sm_product_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_len = 8'd1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_sat;

  int errs = 0;
  int checks = 0;

  sm_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .cfg_len_i(cfg_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_prod_i(in_prod),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_sat_o(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one beat once in_ready is seen; returns on the falling edge after it is taken.
  task automatic send(input logic [15:0] p);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b1;
    in_prod  = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag, input logic [15:0] exp_sum, input logic exp_sat);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_lo", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_hi", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] pat [6];
    logic        vld [6];
    @(negedge clk);
    reset_seq();

    // single-term sum and OUT handshake
    cfg_len = 8'd1;
    send(16'h0005);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum",   32'(out_sum),   32'h5);
    chk("t1_sat",   32'(out_sat),   32'd0);
    chk("t1_ready_out", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_ready_back", 32'(in_ready), 32'd1);

    // mixed signs incl. negative zero: 3-5+7-0 = 5
    cfg_len = 8'd4;
    send(16'h0003); send(16'h8005); send(16'h0007); send(16'h8000);
    take("t2a", 16'h0005, 1'b0);
    cfg_len = 8'd0;
    send(16'h8003);
    take("t2b", 16'hFFFD, 1'b0);

    // saturation both directions
    cfg_len = 8'd3;
    send(16'h7FFF); send(16'h7FFF); send(16'h7FFF);
    take("t3pos", 16'h7FFF, 1'b1);
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
    take("t3neg", 16'h8000, 1'b1);

    // gapped in_valid; invalid cycles carry junk that must be ignored
    pat = '{16'h0001, 16'h0100, 16'h0100, 16'h0002, 16'h0100, 16'h0003};
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cfg_len = 8'd3;
    for (int i = 0; i < 6; i++) begin
      in_valid = vld[i];
      in_prod  = pat[i];
      @(negedge clk);
      if (i == 4) chk("t4a_not_yet", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    take("t4a", 16'h0006, 1'b0);

    // back-pressure: held outputs, no acceptance while in OUT
    cfg_len = 8'd2;
    send(16'd10); send(16'd20);
    in_valid = 1'b1;
    in_prod  = 16'h0063;
    for (int i = 0; i < 5; i++) begin
      chk("t4b_hold_valid", 32'(out_valid), 32'd1);
      chk("t4b_hold_sum",   32'(out_sum),   32'd30);
      chk("t4b_hold_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4b_released", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_prod = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    take("t4b_next", 16'h0064, 1'b0);

    // cfg_len change mid-sum takes effect on the next sum only
    cfg_len = 8'd4;
    send(16'd1);
    cfg_len = 8'd2;
    send(16'd2); send(16'd3);
    chk("t5_still_acc", 32'(out_valid), 32'd0);
    send(16'd4);
    take("t5a", 16'd10, 1'b0);
    send(16'd5); send(16'd6);
    take("t5b", 16'd11, 1'b0);

    // abort mid-sum via reset, then a clean sum
    cfg_len = 8'd4;
    send(16'd7); send(16'd8);
    reset_seq();
    cfg_len = 8'd2;
    send(16'h0001); send(16'h0002);
    take("t6", 16'h0003, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
